// File: rtl/weight_buffer_pingpong.sv
// Double-buffered 3x3 kernel weight store: packs 9 taps per lane into one window word,
// fills one bank from a valid/ready stream while the other bank is served to the PE array.
module weight_buffer_pingpong #(
  parameter int    DATA_W        = 4,
  parameter int    N_LANE        = 8,
  parameter int    DEPTH         = 512,
  parameter int    ADDR_BIT      = 9,
  parameter string RAM_STYLE_VAL = "block"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_LANE*DATA_W-1:0]     in_data,
  input  logic                         in_last,
  output logic                         bank_full,
  output logic [ADDR_BIT:0]            wr_count,
  input  logic                         swap,
  output logic                         rd_bank,
  output logic [ADDR_BIT:0]            rd_count,
  input  logic                         rd_en,
  input  logic [ADDR_BIT-1:0]          rd_addr,
  output logic [N_LANE*9*DATA_W-1:0]   rd_data,
  output logic                         rd_valid
);

  localparam int TAPS   = 9;
  localparam int WORD_W = N_LANE * TAPS * DATA_W;

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t              state, state_nxt;
  logic [3:0]          tap;
  logic [ADDR_BIT-1:0] wr_addr, wr_addr_q;
  logic                fill_bank, wr_bank_q, wr_pend;
  logic [WORD_W-1:0]   staging;
  logic                accept, last_tap, go_full, do_swap;

  // An empty style string leaves RAM mapping to the synthesis tool.
  if (RAM_STYLE_VAL == "") begin : g_mem
    logic [WORD_W-1:0] bank0 [DEPTH];
    logic [WORD_W-1:0] bank1 [DEPTH];
  end else begin : g_mem
    (* ram_style = RAM_STYLE_VAL *) logic [WORD_W-1:0] bank0 [DEPTH];
    (* ram_style = RAM_STYLE_VAL *) logic [WORD_W-1:0] bank1 [DEPTH];
  end

  assign accept   = in_valid && (state == S_FILL);
  assign last_tap = (tap == 4'd8);
  assign go_full  = accept && last_tap && (in_last || (wr_addr == ADDR_BIT'(DEPTH - 1)));
  assign do_swap  = swap && (state == S_FULL);
  assign rd_bank  = ~fill_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    in_ready  = 1'b0;
    bank_full = 1'b0;
    unique case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (go_full) state_nxt = S_FULL;
      end
      S_FULL: begin
        bank_full = 1'b1;
        if (swap) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
    if (clear) state_nxt = S_FILL;
  end

  // A completed word is written one edge after its tap-8 beat, using the latched bank
  // and address, so a swap or clear on that edge cannot redirect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap       <= '0;
      wr_addr   <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      fill_bank <= 1'b0;
      wr_pend   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
    end else if (clear) begin
      tap       <= '0;
      wr_addr   <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      fill_bank <= 1'b0;
      wr_pend   <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (accept) begin
        if (last_tap) begin
          tap       <= '0;
          wr_pend   <= 1'b1;
          wr_bank_q <= fill_bank;
          wr_addr_q <= wr_addr;
          wr_addr   <= wr_addr + 1'b1;
          wr_count  <= wr_count + 1'b1;
        end else begin
          tap <= tap + 4'd1;
        end
      end
      if (do_swap) begin
        fill_bank <= ~fill_bank;
        rd_count  <= wr_count;
        wr_addr   <= '0;
        wr_count  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < N_LANE; l++) begin
        for (int t = 0; t < TAPS; t++) begin
          if (tap == 4'(t))
            staging[(l*TAPS + t)*DATA_W +: DATA_W] <= in_data[l*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: RAM arrays and the staging register carry no reset so they map onto block RAM/plain flops.
  always_ff @(posedge clk) begin
    if (wr_pend) begin
      if (wr_bank_q) g_mem.bank1[wr_addr_q] <= staging;
      else           g_mem.bank0[wr_addr_q] <= staging;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_bank ? g_mem.bank1[rd_addr] : g_mem.bank0[rd_addr];
    end
  end

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// Self-checking bench for weight_buffer_pingpong: directed table, corner sequences,
// and a randomized phase scored against a bank/queue reference model.
module tb_weight_buffer_pingpong;

  localparam int DATA_W   = 4;
  localparam int N_LANE   = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_BIT = 4;
  localparam int BEAT_W   = N_LANE * DATA_W;
  localparam int WORD_W   = N_LANE * 9 * DATA_W;

  localparam logic [WORD_W-1:0] W_UP   = {N_LANE{36'h987654321}};
  localparam logic [WORD_W-1:0] W_DOWN = {N_LANE{36'h789abcdef}};
  localparam logic [WORD_W-1:0] W_ODD  = {N_LANE{36'h1fdb97531}};

  logic                clk = 1'b0;
  logic                rst, clear, in_valid, in_last, swap, rd_en;
  logic [BEAT_W-1:0]   in_data;
  logic [ADDR_BIT-1:0] rd_addr;
  logic                in_ready, bank_full, rd_bank, rd_valid;
  logic [ADDR_BIT:0]   wr_count, rd_count;
  logic [WORD_W-1:0]   rd_data;

  weight_buffer_pingpong #(
    .DATA_W(DATA_W), .N_LANE(N_LANE), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT), .RAM_STYLE_VAL("block")
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .bank_full(bank_full), .wr_count(wr_count),
    .swap(swap), .rd_bank(rd_bank), .rd_count(rd_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: two banks of window words, a queue of the beats of the kernel in progress.
  logic [WORD_W-1:0] m_mem [2][DEPTH];
  logic [BEAT_W-1:0] m_taps [$];
  bit                m_full, m_fill, m_rd_valid;
  int                m_wc, m_rc;
  logic [WORD_W-1:0] m_rd_data;

  function automatic logic [WORD_W-1:0] pack(input logic [BEAT_W-1:0] beats [$]);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int l = 0; l < N_LANE; l++)
      for (int t = 0; t < 9; t++)
        w[(l*9 + t)*DATA_W +: DATA_W] = beats[t][l*DATA_W +: DATA_W];
    return w;
  endfunction

  function automatic logic [BEAT_W-1:0] rep(input logic [DATA_W-1:0] v);
    logic [BEAT_W-1:0] b;
    for (int l = 0; l < N_LANE; l++) b[l*DATA_W +: DATA_W] = v;
    return b;
  endfunction

  task automatic model_reset();
    m_taps.delete();
    m_full = 0; m_fill = 0; m_wc = 0; m_rc = 0;
    m_rd_valid = 0; m_rd_data = '0;
  endtask

  task automatic model_edge();
    if (clear) begin
      m_taps.delete();
      m_full = 0; m_fill = 0; m_wc = 0; m_rc = 0; m_rd_valid = 0;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = m_mem[m_fill ? 0 : 1][rd_addr];
      if (!m_full) begin
        if (in_valid) begin
          m_taps.push_back(in_data);
          if (m_taps.size() == 9) begin
            m_mem[m_fill][m_wc] = pack(m_taps);
            m_wc++;
            m_taps.delete();
            if (in_last || m_wc == DEPTH) m_full = 1;
          end
        end
      end else if (swap) begin
        m_rc = m_wc; m_wc = 0; m_fill = !m_fill; m_full = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " in_ready"},  in_ready,  !m_full);
    check({tag, " bank_full"}, bank_full, m_full);
    check({tag, " wr_count"},  wr_count,  m_wc);
    check({tag, " rd_count"},  rd_count,  m_rc);
    check({tag, " rd_bank"},   rd_bank,   !m_fill);
    check({tag, " rd_valid"},  rd_valid,  m_rd_valid);
    check({tag, " rd_data"},   rd_data,   m_rd_data);
  endtask

  // One kernel with every lane's tap t = base + t*step; gap inserts an idle cycle per beat.
  task automatic load_kernel(input logic [3:0] base, input int step, input bit last, input bit gap);
    for (int t = 0; t < 9; t++) begin
      in_valid = 1'b1;
      in_data  = rep(4'(int'(base) + t*step));
      in_last  = last && (t == 8);
      tick();
      if (gap) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = $urandom;
        tick();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  typedef struct {
    logic              valid;
    logic [BEAT_W-1:0] data;
    logic              last;
    logic              exp_ready;
    logic              exp_full;
    logic [ADDR_BIT:0] exp_wc;
  } vec_t;

  vec_t vecs [18];

  initial begin
    for (int i = 0; i < 18; i++) begin
      vecs[i].valid     = 1'b1;
      vecs[i].data      = rep(4'(i % 9 + 1));
      vecs[i].last      = (i == 17);
      vecs[i].exp_ready = (i != 17);
      vecs[i].exp_full  = (i == 17);
      vecs[i].exp_wc    = (i >= 17) ? 5'd2 : (i >= 8) ? 5'd1 : 5'd0;
    end

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; swap = 1'b0;
    rd_en = 1'b0; in_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",  in_ready,  1'b1);
    check("rst bank_full", bank_full, 1'b0);
    check("rst rd_bank",   rd_bank,   1'b1);
    check("rst rd_count",  rd_count,  '0);
    check("rst wr_count",  wr_count,  '0);
    check("rst rd_data",   rd_data,   '0);
    check("rst rd_valid",  rd_valid,  1'b0);
    rst = 1'b0;
    model_reset();

    // Two kernels, taps t+1, in_last on beat 18.
    for (int i = 0; i < 18; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      in_last  = vecs[i].last;
      tick();
      check($sformatf("load2 ready %0d", i), in_ready,  vecs[i].exp_ready);
      check($sformatf("load2 full %0d", i),  bank_full, vecs[i].exp_full);
      check($sformatf("load2 wc %0d", i),    wr_count,  vecs[i].exp_wc);
    end
    in_valid = 1'b0; in_last = 1'b0;
    in_data = '1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full blocks beat", wr_count, 5'd2);
    do_swap();
    check("swap rd_bank",   rd_bank,   1'b0);
    check("swap rd_count",  rd_count,  5'd2);
    check("swap wr_count",  wr_count,  5'd0);
    check("swap in_ready",  in_ready,  1'b1);
    rd_en = 1'b1; rd_addr = 0;
    tick();
    check("rd0 valid", rd_valid, 1'b1);
    check("rd0 data",  rd_data,  W_UP);
    rd_addr = 1;
    tick();
    check("rd1 data",  rd_data,  W_UP);
    rd_en = 1'b0;
    tick();
    check("rd idle valid", rd_valid, 1'b0);
    check("rd idle hold",  rd_data,  W_UP);

    // Swap while filling is ignored; swap with a read returns the pre-swap bank.
    do_swap();
    check("fill swap rd_bank",  rd_bank,  1'b0);
    check("fill swap rd_count", rd_count, 5'd2);
    check("fill swap ready",    in_ready, 1'b1);
    load_kernel(4'd15, -1, 1'b1, 1'b0);
    check("down full", bank_full, 1'b1);
    check("down wc",   wr_count,  5'd1);
    swap = 1'b1; rd_en = 1'b1; rd_addr = 0;
    tick();
    swap = 1'b0;
    check("swap+rd old data", rd_data,  W_UP);
    check("swap+rd rd_bank",  rd_bank,  1'b1);
    check("swap+rd rd_count", rd_count, 5'd1);
    tick();
    check("after swap new data", rd_data, W_DOWN);
    rd_en = 1'b0;

    // 144 beats without a valid in_last: fills all DEPTH words, then stalls.
    for (int i = 0; i < 144; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = (i % 9 != 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i == 134) check("depth not full at 15", bank_full, 1'b0);
    end
    in_last = 1'b0;
    check("depth full",     bank_full, 1'b1);
    check("depth wr_count", wr_count,  5'd16);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      check("depth stall ready", in_ready, 1'b0);
      check("depth stall wc",    wr_count, 5'd16);
    end
    in_valid = 1'b0;
    do_swap();
    check("depth rd_count", rd_count, 5'd16);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick();
      cmp_model($sformatf("depth rd %0d", a));
    end
    rd_en = 1'b0;

    // Same two-kernel load with in_valid toggling every cycle.
    load_kernel(4'd1, 1, 1'b0, 1'b1);
    load_kernel(4'd1, 1, 1'b1, 1'b1);
    check("toggle wc",   wr_count,  5'd2);
    check("toggle full", bank_full, 1'b1);
    do_swap();
    rd_en = 1'b1; rd_addr = 0;
    tick();
    check("toggle rd0", rd_data, W_UP);
    rd_addr = 1;
    tick();
    check("toggle rd1", rd_data, W_UP);
    rd_en = 1'b0;

    // Asynchronous reset mid-kernel.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = rep(4'hE);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst in_ready", in_ready, 1'b1);
    check("async rst rd_count", rd_count, '0);
    check("async rst rd_data",  rd_data,  '0);
    check("async rst rd_bank",  rd_bank,  1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Clear mid-kernel discards the partial beats.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rep(4'h6);
      tick();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear wc",    wr_count, 5'd0);
    check("clear ready", in_ready, 1'b1);
    load_kernel(4'd1, 2, 1'b1, 1'b0);
    check("post clear wc",   wr_count,  5'd1);
    check("post clear full", bank_full, 1'b1);
    do_swap();
    check("post clear rd_count", rd_count, 5'd1);
    rd_en = 1'b1; rd_addr = 0;
    tick();
    check("post clear word", rd_data, W_ODD);
    rd_en = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_last  = ($urandom_range(0, 7) == 0);
      swap     = ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 299) == 0);
      if (m_rc > 0 && $urandom_range(0, 1) == 1) begin
        rd_en   = 1'b1;
        rd_addr = 4'($urandom_range(0, m_rc - 1));
      end else begin
        rd_en   = 1'b0;
        rd_addr = 4'($urandom);
      end
      tick();
      cmp_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
